tile_map_writer: RTL and testbench

- Write-side counterpart to the VGA tile renderer. The renderer reads 4-bit tile codes from the SB_RAM40_4K map (4 tiles per 16-bit word); this block writes them.
- Accepts single-tile write requests from game logic (car, player, level blocks) through a valid/ready FIFO. Also accepts a whole-map fill command for level reset.
- Commits every change to BRAM by read-modify-write, only during vertical blanking, so the renderer never sees a half-updated frame.

---
 rtl/tile_pkg.sv | 48 ++++
 rtl/tile_write_fifo.sv | 50 +++++
 rtl/tile_map_writer.sv | 190 +++++++++++++++++++
 tb/tb_tile_map_writer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared tile-map definitions used by both the tile writer and the VGA tile renderer.
package tile_pkg;

    localparam int MAP_COLS          = 20;
    localparam int MAP_ROWS          = 15;
    localparam int ROW_STRIDE        = 8;
    localparam int MAP_WORDS_PER_ROW = (MAP_COLS + 3) / 4;
    localparam int DEF_FIFO_DEPTH    = 8;
    localparam int DEF_ADDR_W        = 11;

    localparam logic [3:0] TILE_CAR    = 4'd0;
    localparam logic [3:0] TILE_GRASS  = 4'd1;
    localparam logic [3:0] TILE_PLAYER = 4'd2;
    localparam logic [3:0] TILE_BLACK  = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_MERGE = 2'd2,
        ST_FILL  = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic [4:0] x;
        logic [3:0] y;
        logic [3:0] tile;
    } tile_req_t;

    // Four tiles share one 16-bit word; rows are padded out to ROW_STRIDE words.
    function automatic logic [DEF_ADDR_W-1:0] word_addr(input logic [4:0] x, input logic [3:0] y);
        return DEF_ADDR_W'(y) * DEF_ADDR_W'(ROW_STRIDE) + DEF_ADDR_W'(x[4:2]);
    endfunction

    // The leftmost tile of a word lives in the most significant nibble.
    function automatic logic [15:0] put_nibble(input logic [15:0] word, input logic [1:0] sel,
                                               input logic [3:0] tile);
        logic [15:0] result;
        result = word;
        case (sel)
            2'd0:    result[15:12] = tile;
            2'd1:    result[11:8]  = tile;
            2'd2:    result[7:4]   = tile;
            default: result[3:0]   = tile;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/tile_write_fifo.sv
// Small synchronous FIFO holding pending single-tile writes {x, y, tile}.
module tile_write_fifo import tile_pkg::*; #(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     i_Clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  tile_req_t                i_data,
    input  logic                     i_pop,
    output tile_req_t                o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    tile_req_t        mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (i_push && !o_full)
                wr_ptr <= wr_ptr + 1'b1;
            if (i_pop && !o_empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; only the pointers decide what is valid.
    always_ff @(posedge i_Clk) begin
        if (i_push && !o_full && !i_flush)
            mem[wr_ptr[PTR_W-1:0]] <= i_data;
    end

    assign o_count = wr_ptr - rd_ptr;
    assign o_full  = (o_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_head  = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/tile_map_writer.sv
// Commits queued tile writes and whole-map fills to the tile-map BRAM during vertical blanking.
module tile_map_writer import tile_pkg::*; #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              i_Clk,
    input  logic              i_reset,
    input  logic              i_vblank,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [4:0]        i_cell_x,
    input  logic [3:0]        i_cell_y,
    input  logic [3:0]        i_tile,
    input  logic              i_fill_req,
    input  logic [3:0]        i_fill_tile,
    output logic              o_fill_busy,
    output logic              o_drop,
    output logic              o_raddr_own,
    output logic [ADDR_W-1:0] o_bram_raddr,
    input  logic [15:0]       i_bram_rdata,
    output logic [ADDR_W-1:0] o_bram_waddr,
    output logic [15:0]       o_bram_wdata,
    output logic              o_bram_we
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wr_state_t          state;
    wr_state_t          state_next;

    tile_req_t          head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    logic               fill_busy;
    logic [3:0]         fill_tile;
    logic [3:0]         fill_row;
    logic [2:0]         fill_col;

    logic               fwd_valid;
    logic [ADDR_W-1:0]  fwd_addr;
    logic [15:0]        fwd_data;
    logic               drop;

    logic               handshake;
    logic               in_range;
    logic               push;
    logic               fifo_more;
    logic               fill_last;
    logic [ADDR_W-1:0]  head_addr;
    logic [ADDR_W-1:0]  fill_addr;
    logic [15:0]        base_word;
    logic [15:0]        merged_word;

    assign o_wr_ready  = !i_reset && !fifo_full && !fill_busy && !i_fill_req;
    assign handshake   = i_wr_valid && o_wr_ready;
    assign in_range    = (i_cell_x < 5'(MAP_COLS)) && (i_cell_y < 4'(MAP_ROWS));
    assign push        = handshake && in_range;
    assign fifo_more   = (fifo_count > CNT_W'(1)) || push;

    assign head_addr   = ADDR_W'(word_addr(head.x, head.y));
    assign base_word   = (fwd_valid && (fwd_addr == head_addr)) ? fwd_data : i_bram_rdata;
    assign merged_word = put_nibble(base_word, head.x[1:0], head.tile);

    assign fill_addr   = ADDR_W'(fill_row) * ADDR_W'(ROW_STRIDE) + ADDR_W'(fill_col);
    assign fill_last   = (fill_row == 4'(MAP_ROWS - 1)) && (fill_col == 3'(MAP_WORDS_PER_ROW - 1));

    assign o_fill_busy = fill_busy;
    assign o_drop      = drop;

    tile_write_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .i_Clk   (i_Clk),
        .i_reset (i_reset),
        .i_flush (state == ST_FILL),
        .i_push  (push),
        .i_data  ({i_cell_x, i_cell_y, i_tile}),
        .i_pop   (state == ST_MERGE),
        .o_head  (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // State register; reset abandons whatever was in flight.
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Work only begins inside vblank; a fill always wins over queued single writes.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_vblank && fill_busy)
                    state_next = ST_FILL;
                else if (i_vblank && !fifo_empty)
                    state_next = ST_READ;
            end
            ST_READ:  state_next = ST_MERGE;
            ST_MERGE: state_next = (i_vblank && fifo_more) ? ST_READ : ST_IDLE;
            ST_FILL: begin
                if (fill_last && !i_fill_req)
                    state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // BRAM port drive is purely a function of state so reset kills the write strobe at once.
    always_comb begin
        o_raddr_own  = 1'b0;
        o_bram_raddr = '0;
        o_bram_waddr = '0;
        o_bram_wdata = '0;
        o_bram_we    = 1'b0;
        case (state)
            ST_READ: begin
                o_raddr_own  = 1'b1;
                o_bram_raddr = head_addr;
            end
            ST_MERGE: begin
                o_bram_we    = 1'b1;
                o_bram_waddr = head_addr;
                o_bram_wdata = merged_word;
            end
            ST_FILL: begin
                o_bram_we    = 1'b1;
                o_bram_waddr = fill_addr;
                o_bram_wdata = {4{fill_tile}};
            end
            default: ;
        endcase
    end

    // A fill request (re)starts the row-major sweep from word 0 with the new tile.
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            fill_busy <= 1'b0;
            fill_tile <= '0;
            fill_row  <= '0;
            fill_col  <= '0;
        end else if (i_fill_req) begin
            fill_busy <= 1'b1;
            fill_tile <= i_fill_tile;
            fill_row  <= '0;
            fill_col  <= '0;
        end else if (state == ST_FILL) begin
            if (fill_last) begin
                fill_busy <= 1'b0;
                fill_row  <= '0;
                fill_col  <= '0;
            end else if (fill_col == 3'(MAP_WORDS_PER_ROW - 1)) begin
                fill_col  <= '0;
                fill_row  <= fill_row + 1'b1;
            end else begin
                fill_col  <= fill_col + 1'b1;
            end
        end
    end

    // Remember the last merged word so consecutive writes to one word never use stale read data.
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else if (state == ST_FILL) begin
            fwd_valid <= 1'b0;
        end else if (state == ST_MERGE) begin
            fwd_valid <= 1'b1;
            fwd_addr  <= head_addr;
            fwd_data  <= merged_word;
        end
    end

    // Sticky flag for accepted requests that point outside the visible map.
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset)
            drop <= 1'b0;
        else if (handshake && !in_range)
            drop <= 1'b1;
    end

endmodule

// File: tb/tb_tile_map_writer.sv
// Directed bench for tile_map_writer: BRAM model, word-level map model and per-cycle write checker.
module tb_tile_map_writer;
    import tile_pkg::*;

    typedef struct packed {
        logic [10:0] addr;
        logic [15:0] data;
    } exp_wr_t;

    logic        i_Clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_vblank = 1'b0;
    logic        i_wr_valid = 1'b0;
    logic        o_wr_ready;
    logic [4:0]  i_cell_x = '0;
    logic [3:0]  i_cell_y = '0;
    logic [3:0]  i_tile = '0;
    logic        i_fill_req = 1'b0;
    logic [3:0]  i_fill_tile = '0;
    logic        o_fill_busy;
    logic        o_drop;
    logic        o_raddr_own;
    logic [10:0] o_bram_raddr;
    logic [15:0] i_bram_rdata = '0;
    logic [10:0] o_bram_waddr;
    logic [15:0] o_bram_wdata;
    logic        o_bram_we;

    logic [15:0] bram_mem [0:2047];
    logic [15:0] shadow   [0:2047];
    exp_wr_t     exp_q [$];

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int we_run = 0;
    int last_run = 0;
    int base_count;
    bit done;

    tile_map_writer dut (
        .i_Clk        (i_Clk),
        .i_reset      (i_reset),
        .i_vblank     (i_vblank),
        .i_wr_valid   (i_wr_valid),
        .o_wr_ready   (o_wr_ready),
        .i_cell_x     (i_cell_x),
        .i_cell_y     (i_cell_y),
        .i_tile       (i_tile),
        .i_fill_req   (i_fill_req),
        .i_fill_tile  (i_fill_tile),
        .o_fill_busy  (o_fill_busy),
        .o_drop       (o_drop),
        .o_raddr_own  (o_raddr_own),
        .o_bram_raddr (o_bram_raddr),
        .i_bram_rdata (i_bram_rdata),
        .o_bram_waddr (o_bram_waddr),
        .o_bram_wdata (o_bram_wdata),
        .o_bram_we    (o_bram_we)
    );

    always #5 i_Clk = ~i_Clk;

    // Registered-read BRAM, not cleared by reset.
    always @(posedge i_Clk) begin
        i_bram_rdata <= bram_mem[o_bram_raddr];
        if (o_bram_we)
            bram_mem[o_bram_waddr] <= o_bram_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Map model: apply the tile to the word image, queue the word expected in BRAM.
    task automatic model_write(input int x, input int y, input logic [3:0] tile);
        int          addr;
        int          shift;
        logic [15:0] mask;
        logic [15:0] val;
        exp_wr_t     e;
        addr  = y * ROW_STRIDE + x / 4;
        shift = (3 - (x % 4)) * 4;
        mask  = 16'hF << shift;
        val   = {12'h000, tile} << shift;
        shadow[addr] = (shadow[addr] & ~mask) | val;
        e.addr = 11'(addr);
        e.data = shadow[addr];
        exp_q.push_back(e);
    endtask

    task automatic model_fill(input logic [3:0] tile);
        exp_wr_t e;
        exp_q.delete();
        for (int y = 0; y < 15; y++) begin
            for (int w = 0; w < 5; w++) begin
                shadow[y * 8 + w] = {4{tile}};
                e.addr = 11'(y * 8 + w);
                e.data = {4{tile}};
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus(input logic [4:0] x, input logic [3:0] y, input logic [3:0] tile,
                                 input logic exp_ready);
        @(negedge i_Clk);
        i_wr_valid = 1'b1;
        i_cell_x   = x;
        i_cell_y   = y;
        i_tile     = tile;
        #1 checkOutput("wr_ready", {31'b0, o_wr_ready}, {31'b0, exp_ready});
        @(posedge i_Clk);
        #1 i_wr_valid = 1'b0;
        if (exp_ready && int'(x) < 20 && int'(y) < 15)
            model_write(int'(x), int'(y), tile);
    endtask

    task automatic wait_drained(input string name, input int budget);
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge i_Clk);
            #2;
            if (exp_q.size() == 0 && !o_bram_we)
                done = 1;
        end
        checkOutput(name, {31'b0, done}, 32'd1);
    endtask

    // Every write the DUT issues must be the next one the model expects, in order.
    initial begin
        exp_wr_t e;
        forever begin
            @(negedge i_Clk);
            if (o_bram_we === 1'b1) begin
                wr_count++;
                we_run++;
                last_run = we_run;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write actual addr=%0d data=%h required=no write",
                             o_bram_waddr, o_bram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (o_bram_waddr !== e.addr || o_bram_wdata !== e.data) begin
                        errors++;
                        $display("[TB] FAIL bram_write actual addr=%0d data=%h required addr=%0d data=%h",
                                 o_bram_waddr, o_bram_wdata, e.addr, e.data);
                    end
                end
            end else begin
                we_run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2048; i++) begin
            bram_mem[i] = 16'h0101;
            shadow[i]   = 16'h0101;
        end

        // Reset values
        #1;
        checkOutput("rst_we",       {31'b0, o_bram_we},   32'd0);
        checkOutput("rst_own",      {31'b0, o_raddr_own}, 32'd0);
        checkOutput("rst_drop",     {31'b0, o_drop},      32'd0);
        checkOutput("rst_busy",     {31'b0, o_fill_busy}, 32'd0);
        checkOutput("rst_ready",    {31'b0, o_wr_ready},  32'd0);
        checkOutput("rst_waddr",    {21'b0, o_bram_waddr}, 32'd0);
        @(negedge i_Clk);
        i_reset = 1'b0;

        // Single write waits for vblank, then READ then MERGE
        applyStimulus(5'd5, 4'd3, 4'd2, 1'b1);
        repeat (5) @(posedge i_Clk);
        checkOutput("no_write_outside_vblank", wr_count, 0);
        @(negedge i_Clk);
        i_vblank = 1'b1;
        @(negedge i_Clk);
        checkOutput("read_own",  {31'b0, o_raddr_own}, 32'd1);
        checkOutput("read_addr", {21'b0, o_bram_raddr}, 32'd25);
        @(posedge i_Clk);
        #2;
        checkOutput("merge_we",    {31'b0, o_bram_we}, 32'd1);
        checkOutput("merge_waddr", {21'b0, o_bram_waddr}, 32'd25);
        checkOutput("merge_wdata", {16'b0, o_bram_wdata}, 32'h0201);
        wait_drained("first_drained", 20);
        checkOutput("word25", {16'b0, bram_mem[25]}, 32'h0201);

        // Two writes into the same word
        applyStimulus(5'd4, 4'd0, 4'd0, 1'b1);
        applyStimulus(5'd7, 4'd0, 4'd2, 1'b1);
        wait_drained("pair_drained", 20);
        checkOutput("word1", {16'b0, bram_mem[1]}, 32'h0102);

        // Fill the FIFO outside vblank; the ninth request is refused
        @(negedge i_Clk);
        i_vblank = 1'b0;
        base_count = wr_count;
        for (int i = 0; i < 9; i++)
            applyStimulus(5'(i), 4'd2, 4'((i * 3) % 16), (i < 8) ? 1'b1 : 1'b0);
        @(negedge i_Clk);
        i_vblank = 1'b1;
        wait_drained("fifo8_drained", 60);
        checkOutput("fifo8_writes", wr_count - base_count, 8);
        checkOutput("ready_back", {31'b0, o_wr_ready}, 32'd1);
        checkOutput("word16", {16'b0, bram_mem[16]}, 32'h0369);
        checkOutput("word17", {16'b0, bram_mem[17]}, 32'hCF25);

        // vblank drops during MERGE: that write lands, the rest wait
        @(negedge i_Clk);
        i_vblank = 1'b0;
        applyStimulus(5'd10, 4'd4, 4'd2, 1'b1);
        applyStimulus(5'd12, 4'd5, 4'd0, 1'b1);
        applyStimulus(5'd1,  4'd14, 4'd3, 1'b1);
        base_count = wr_count;
        @(negedge i_Clk);
        i_vblank = 1'b1;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge i_Clk);
            if (o_raddr_own)
                done = 1;
        end
        checkOutput("saw_read", {31'b0, done}, 32'd1);
        @(posedge i_Clk);
        #1 i_vblank = 1'b0;
        repeat (6) @(posedge i_Clk);
        #2;
        checkOutput("vblank_end_writes", wr_count - base_count, 1);
        checkOutput("vblank_end_pending", exp_q.size(), 2);
        checkOutput("vblank_end_own", {31'b0, o_raddr_own}, 32'd0);
        @(negedge i_Clk);
        i_vblank = 1'b1;
        wait_drained("resume_drained", 20);
        checkOutput("resume_writes", wr_count - base_count, 3);

        // Out-of-range requests set the sticky drop flag and never write
        base_count = wr_count;
        applyStimulus(5'd20, 4'd3, 4'd1, 1'b1);
        repeat (5) @(posedge i_Clk);
        #2;
        checkOutput("drop_x", {31'b0, o_drop}, 32'd1);
        checkOutput("drop_x_nowrite", wr_count - base_count, 0);
        @(negedge i_Clk);
        i_reset = 1'b1;
        #1 checkOutput("drop_cleared", {31'b0, o_drop}, 32'd0);
        @(negedge i_Clk);
        i_reset = 1'b0;
        applyStimulus(5'd3, 4'd15, 4'd1, 1'b1);
        repeat (5) @(posedge i_Clk);
        #2;
        checkOutput("drop_y", {31'b0, o_drop}, 32'd1);
        checkOutput("drop_y_nowrite", wr_count - base_count, 0);

        // Fill supersedes queued writes; a write alongside the fill pulse is refused
        @(negedge i_Clk);
        i_vblank = 1'b0;
        applyStimulus(5'd2,  4'd1,  4'd3, 1'b1);
        applyStimulus(5'd19, 4'd14, 4'd0, 1'b1);
        @(negedge i_Clk);
        i_fill_req  = 1'b1;
        i_fill_tile = 4'd1;
        i_wr_valid  = 1'b1;
        i_cell_x    = 5'd6;
        i_cell_y    = 4'd6;
        i_tile      = 4'd2;
        #1 checkOutput("ready_with_fill", {31'b0, o_wr_ready}, 32'd0);
        model_fill(4'd1);
        @(posedge i_Clk);
        #1;
        i_fill_req = 1'b0;
        i_wr_valid = 1'b0;
        @(negedge i_Clk);
        checkOutput("fill_busy_rise", {31'b0, o_fill_busy}, 32'd1);
        base_count = wr_count;
        i_vblank = 1'b1;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge i_Clk);
            #2;
            if (!o_fill_busy)
                done = 1;
        end
        checkOutput("fill_done", {31'b0, done}, 32'd1);
        checkOutput("fill_we_after", {31'b0, o_bram_we}, 32'd0);
        checkOutput("fill_run", last_run, 75);
        checkOutput("fill_writes", wr_count - base_count, 75);
        checkOutput("fill_pending", exp_q.size(), 0);
        checkOutput("fill_word0",   {16'b0, bram_mem[0]},   32'h1111);
        checkOutput("fill_word116", {16'b0, bram_mem[116]}, 32'h1111);
        checkOutput("fill_word5",   {16'b0, bram_mem[5]},   32'h0101);
        checkOutput("ready_after_fill", {31'b0, o_wr_ready}, 32'd1);

        // Asynchronous reset in the middle of a fill
        @(negedge i_Clk);
        i_fill_req  = 1'b1;
        i_fill_tile = 4'd2;
        model_fill(4'd2);
        @(posedge i_Clk);
        #1 i_fill_req = 1'b0;
        repeat (12) @(posedge i_Clk);
        #2;
        checkOutput("midfill_we", {31'b0, o_bram_we}, 32'd1);
        i_reset = 1'b1;
        #1;
        checkOutput("reset_we",   {31'b0, o_bram_we},   32'd0);
        checkOutput("reset_busy", {31'b0, o_fill_busy}, 32'd0);
        exp_q.delete();
        base_count = wr_count;
        @(negedge i_Clk);
        i_reset = 1'b0;
        repeat (5) @(posedge i_Clk);
        #2;
        checkOutput("reset_nowrite", wr_count - base_count, 0);
        checkOutput("mixed_word0",   {16'b0, bram_mem[0]},   32'h2222);
        checkOutput("mixed_word116", {16'b0, bram_mem[116]}, 32'h1111);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
